pong_engine: RTL and testbench

PONG_ENGINE -- requirements
Module: pong_engine

---
 rtl/pong_engine.sv | 117 +++++++++++
 tb/tb_pong_engine.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// pong_engine: one-dimensional LED pong with a rally timer that speeds up on every
// return and two-digit BCD scoring up to a configurable winning score.
module pong_engine #(
  parameter int N_LEDS    = 18,
  parameter int WIN_PTS   = 13,
  parameter int TICK_MAX  = 25000000,
  parameter int TICK_MIN  = 2500000,
  parameter int TICK_STEP = 2500000
) (
  input  logic              clk,
  input  logic              CLRN,
  input  logic              start,
  input  logic              btn_l,
  input  logic              btn_r,
  output logic [N_LEDS-1:0] ball,
  output logic [7:0]        score_l,
  output logic [7:0]        score_r,
  output logic [2:0]        state,
  output logic              game_over
);
  typedef enum logic [2:0] {IDLE, SERVE, MOVE, POINT, WAIT, OVER} state_t;
  localparam logic [7:0]  WIN_BCD = 8'(((WIN_PTS / 10) << 4) | (WIN_PTS % 10));
  localparam logic [31:0] P_MAX   = 32'(TICK_MAX);
  localparam logic [31:0] P_MIN   = 32'(TICK_MIN);
  localparam logic [31:0] P_STEP  = 32'(TICK_STEP);

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    return s == 8'h99 ? s : s[3:0] == 4'd9 ? {s[7:4] + 4'd1, 4'd0} : s + 8'd1;
  endfunction

  // r_dir: 0 = travelling right (toward bit 0), 1 = travelling left; r_server: 0 = left
  state_t            r_state, w_state_n;
  logic [N_LEDS-1:0] r_ball, w_ball_n;
  logic [7:0]        r_score_l, r_score_r, w_score_l_n, w_score_r_n, w_inc;
  logic              r_dir, r_server, w_dir_n, w_server_n;
  logic [31:0]       r_period, r_cnt, w_period_n, w_cnt_n, w_per_dec;
  logic              w_tick, w_at_dst, w_btn;

  assign ball      = r_ball;
  assign score_l   = r_score_l;
  assign score_r   = r_score_r;
  assign state     = r_state;
  assign game_over = r_state == OVER;

  always_comb begin
    w_state_n   = r_state;
    w_ball_n    = r_ball;
    w_score_l_n = r_score_l;
    w_score_r_n = r_score_r;
    w_dir_n     = r_dir;
    w_server_n  = r_server;
    w_period_n  = r_period;
    w_cnt_n     = r_cnt;
    w_tick      = r_cnt == 32'd0;
    w_at_dst    = r_dir ? r_ball[N_LEDS-1] : r_ball[0];
    w_btn       = r_dir ? btn_l : btn_r;
    w_inc       = r_dir ? bcd_inc(r_score_r) : bcd_inc(r_score_l);
    w_per_dec   = r_period >= P_MIN + P_STEP ? r_period - P_STEP : P_MIN;
    case (r_state)
      IDLE, OVER: if (start) begin
        w_score_l_n = '0;
        w_score_r_n = '0;
        w_server_n  = 1'b0;
        w_state_n   = SERVE;
      end
      SERVE: begin
        w_ball_n   = r_server ? N_LEDS'(1) : {1'b1, {(N_LEDS-1){1'b0}}};
        w_dir_n    = r_server;
        w_period_n = P_MAX;
        w_cnt_n    = P_MAX - 32'd1;
        w_state_n  = MOVE;
      end
      MOVE: begin
        w_cnt_n = w_tick ? r_period - 32'd1 : r_cnt - 32'd1;
        // a valid hit outranks a same-cycle tick; any other press toward the ball is a fault
        if (w_btn && w_at_dst) begin
          w_dir_n    = ~r_dir;
          w_period_n = w_per_dec;
          w_cnt_n    = w_per_dec - 32'd1;
        end else if (w_btn || (w_tick && w_at_dst)) begin
          w_ball_n  = '0;
          w_state_n = POINT;
        end else if (w_tick)
          w_ball_n = r_dir ? r_ball << 1 : r_ball >> 1;
      end
      POINT: begin
        w_score_l_n = r_dir ? r_score_l : w_inc;
        w_score_r_n = r_dir ? w_inc : r_score_r;
        w_server_n  = ~r_dir;
        w_state_n   = w_inc == WIN_BCD ? OVER : WAIT;
      end
      WAIT: if (start) w_state_n = SERVE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge CLRN)
    if (!CLRN) begin
      r_state   <= IDLE;
      r_ball    <= '0;
      r_score_l <= '0;
      r_score_r <= '0;
      r_dir     <= 1'b0;
      r_server  <= 1'b0;
      r_period  <= P_MAX;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_ball    <= w_ball_n;
      r_score_l <= w_score_l_n;
      r_score_r <= w_score_r_n;
      r_dir     <= w_dir_n;
      r_server  <= w_server_n;
      r_period  <= w_period_n;
      r_cnt     <= w_cnt_n;
    end
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed rally, scoring, game-over and reset scenarios with
// N_LEDS=4, TICK_MAX=8, TICK_MIN=2, TICK_STEP=3, WIN_PTS=2.
module tb_pong_engine;
  logic       clk = 0, CLRN = 0, start = 0, btn_l = 0, btn_r = 0;
  logic [3:0] ball;
  logic [7:0] score_l, score_r;
  logic [2:0] state;
  logic       game_over;
  int tests = 0, fails = 0;

  pong_engine #(.N_LEDS(4), .WIN_PTS(2), .TICK_MAX(8), .TICK_MIN(2), .TICK_STEP(3)) dut (
    .clk(clk), .CLRN(CLRN), .start(start), .btn_l(btn_l), .btn_r(btn_r),
    .ball(ball), .score_l(score_l), .score_r(score_r), .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb(input string tag, input logic [2:0] s, input logic [3:0] b);
    chk({tag, "_state"}, 32'(state), 32'(s));
    chk({tag, "_ball"}, 32'(ball), 32'(b));
  endtask

  task automatic sc(input string tag, input logic [7:0] l, input logic [7:0] r);
    chk({tag, "_score_l"}, 32'(score_l), 32'(l));
    chk({tag, "_score_r"}, 32'(score_r), 32'(r));
  endtask

  task automatic pstart;
    start = 1; tk(1); start = 0;
  endtask

  task automatic pl;
    btn_l = 1; tk(1); btn_l = 0;
  endtask

  task automatic pr;
    btn_r = 1; tk(1); btn_r = 0;
  endtask

  initial begin
    #2;
    sb("rst", 3'd0, 4'b0000);
    sc("rst", 8'h00, 8'h00);
    chk("rst_go", 32'(game_over), 32'd0);
    #20 CLRN = 1;
    tk(3);
    sb("idle_hold", 3'd0, 4'b0000);
    pstart;
    sb("serve", 3'd1, 4'b0000);
    tk(1);
    sb("move0", 3'd2, 4'b1000);
    tk(7);
    chk("hold7", 32'(ball), 32'h8);
    tk(1);
    chk("step1", 32'(ball), 32'h4);
    tk(8);
    chk("step2", 32'(ball), 32'h2);
    tk(8);
    chk("step3", 32'(ball), 32'h1);
    pr;
    sb("hit1", 3'd2, 4'b0001);
    tk(4);
    chk("hit1_hold4", 32'(ball), 32'h1);
    tk(1);
    chk("hit1_step5", 32'(ball), 32'h2);
    tk(5);
    chk("p5_a", 32'(ball), 32'h4);
    tk(5);
    chk("p5_b", 32'(ball), 32'h8);
    pl;
    chk("hit2", 32'(ball), 32'h8);
    tk(1);
    chk("hit2_hold1", 32'(ball), 32'h8);
    tk(1);
    chk("hit2_step2", 32'(ball), 32'h4);
    tk(2);
    chk("p2_a", 32'(ball), 32'h2);
    tk(2);
    chk("p2_b", 32'(ball), 32'h1);
    pr;
    chk("hit3", 32'(ball), 32'h1);
    tk(1);
    chk("hit3_hold1", 32'(ball), 32'h1);
    tk(1);
    chk("hit3_floor", 32'(ball), 32'h2);
    pr;
    sb("away_r", 3'd2, 4'b0010);
    tk(1);
    chk("p2_c", 32'(ball), 32'h4);
    tk(2);
    chk("p2_d", 32'(ball), 32'h8);
    tk(2);
    sb("miss_l", 3'd3, 4'b0000);
    sc("miss_l_pt", 8'h00, 8'h00);
    tk(1);
    sb("miss_l_wait", 3'd4, 4'b0000);
    sc("miss_l_wait", 8'h00, 8'h01);
    pstart;
    tk(1);
    sb("serve_l", 3'd2, 4'b1000);
    tk(24);
    chk("at_r", 32'(ball), 32'h1);
    tk(8);
    sb("miss_r", 3'd3, 4'b0000);
    tk(1);
    sb("miss_r_wait", 3'd4, 4'b0000);
    sc("miss_r_wait", 8'h01, 8'h01);
    pstart;
    tk(1);
    sb("serve_r", 3'd2, 4'b0001);
    CLRN = 0;
    #1;
    sb("arst", 3'd0, 4'b0000);
    sc("arst", 8'h00, 8'h00);
    chk("arst_go", 32'(game_over), 32'd0);
    #2 CLRN = 1;
    tk(2);
    sb("arst_idle", 3'd0, 4'b0000);
    pstart;
    tk(1);
    sb("g2_serve", 3'd2, 4'b1000);
    tk(8);
    chk("g2_step", 32'(ball), 32'h4);
    pl;
    sb("away_l", 3'd2, 4'b0100);
    pr;
    sb("fault_r", 3'd3, 4'b0000);
    pstart;
    sb("pt_start_ign", 3'd4, 4'b0000);
    sc("fault_r", 8'h01, 8'h00);
    pstart;
    tk(1);
    sb("g2_serve_r", 3'd2, 4'b0001);
    tk(24);
    chk("g2_at_l", 32'(ball), 32'h8);
    pl;
    sb("g2_hit_l", 3'd2, 4'b1000);
    pr;
    sb("g2_fault_r", 3'd3, 4'b0000);
    tk(1);
    sb("over", 3'd5, 4'b0000);
    sc("over", 8'h02, 8'h00);
    chk("over_go", 32'(game_over), 32'd1);
    pl;
    chk("over_btn_ign", 32'(state), 32'd5);
    pstart;
    sb("new_game", 3'd1, 4'b0000);
    sc("new_game", 8'h00, 8'h00);
    chk("new_game_go", 32'(game_over), 32'd0);
    tk(1);
    sb("new_game_move", 3'd2, 4'b1000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
